uart_tx_framer: RTL

- Next-generation UART transmitter with a parametrised data width and a runtime bit period taken from the baud_edge input.
- Runtime-selectable parity (none/even/odd/mark) and 1 or 2 stop bits.
- Small input FIFO so the host can queue bytes; frames go out back-to-back with no idle gap.
- Sits between the memory-mapped IO block and the pad; serial_out drives the UART TX pin directly.

---
 rtl/uart_tx_framer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter with a small input FIFO, runtime bit period, parity and stop-bit count.
// Optional macro UART_TX_BREAK_EN adds the send_break input and the BREAK state.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int MIN_BDRT   = 9_600,
    parameter int BAUD_BITS  = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2)),
    parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BAUD_BITS-1:0] baud_edge,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 data_in_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 tx_done,
    output logic [CNT_BITS-1:0]  fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS + 4);
    localparam logic [BIT_W-1:0]    LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_BITS-1:0] FULL      = CNT_BITS'(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
    localparam logic [BIT_W-1:0]    BRK_HIGH  = BIT_W'(DATA_BITS + 3);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        , ST_BREAK
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_BITS-1:0]  cnt_q, cnt_d;
    logic [BAUD_BITS-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic                  serial_q, serial_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [DATA_BITS-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  take_next;
    logic                  sym_edge;
    logic [DATA_BITS-1:0]  head;

    always_comb begin
        push      = data_in_valid && (count_q != FULL);
        pop       = 1'b0;
        take_next = 1'b0;
        head      = fifo_mem_q[rd_ptr_q];
        sym_edge  = (cnt_q == baud_q);

        state_d  = state_q;
        cnt_d    = cnt_q + BAUD_BITS'(1);
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                take_next = 1'b1;
            end
            ST_START: begin
                if (sym_edge) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (sym_edge) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (sym_edge) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (sym_edge) begin
                    cnt_d = '0;
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BIT_W'(1);
                    end else begin
                        // Final stop edge: the next frame may start on this same edge.
                        done_d    = 1'b1;
                        bit_d     = '0;
                        state_d   = ST_IDLE;
                        take_next = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (sym_edge) begin
                    cnt_d = '0;
                    if (bit_q == BRK_HIGH) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (take_next) begin
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
                state_d = ST_BREAK;
                cnt_d   = '0;
                bit_d   = '0;
                baud_d  = baud_edge;
            end else
`endif
            if (count_q != '0) begin
                pop      = 1'b1;
                state_d  = ST_START;
                cnt_d    = '0;
                bit_d    = '0;
                shreg_d  = head;
                baud_d   = baud_edge;
                par_en_d = (parity_mode != 2'b00);
                stop2_d  = stop2;
                case (parity_mode)
                    2'b01:   par_d = ^head;
                    2'b10:   par_d = ~^head;
                    default: par_d = 1'b1;
                endcase
            end
        end

        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shreg_d[0];
            ST_PARITY: serial_d = par_d;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  serial_d = (bit_d == BRK_HIGH);
`endif
            default:   serial_d = 1'b1;
        endcase

        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = data_in;
        end
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            serial_q   <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            serial_q   <= serial_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign data_in_ready = (count_q != FULL);
    assign serial_out    = serial_q;
    assign busy          = busy_q;
    assign tx_done       = done_q;
    assign fifo_count    = count_q;

endmodule
